mem_req_arbiter: RTL and testbench
==================================

# mem_req_arbiter

Two-client arbiter placed directly downstream of the HLS-core bus bridges and upstream of a single LEAP scratchpad port. Accepts single-word read/write requests from two bridge instances, grants them round-robin, forwards one transaction at a time to the memory side and routes the acknowledge and read data back to the owning client. Each HLS core keeps its own bridge while sharing one memory.

## Interface
- DATA_WIDTH, 32, data word width
- ADDR_WIDTH, 32, address width
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- writeReq_0 / writeReq_1  in  1  client write request, held until ack
- writeReq_data_0 / _1  in  DATA_WIDTH  write data
- writeReq_addr_0 / _1  in  ADDR_WIDTH  write address
- writeAck_0 / writeAck_1  out  1  one-cycle write completion pulse
- readReq_0 / readReq_1  in  1  client read request, held until ack
- readReq_addr_0 / _1  in  ADDR_WIDTH  read address
- readAck_0 / readAck_1  out  1  one-cycle read completion pulse
- readReq_data_0 / _1  out  DATA_WIDTH  read data, valid in ack cycle, held until next read completion for that client
- mem_writeReq  out  1  memory write request, held until mem_writeAck
- mem_writeReq_data  out  DATA_WIDTH  registered write data
- mem_writeReq_addr  out  ADDR_WIDTH  registered write address
- mem_writeAck  in  1  memory write done pulse
- mem_readReq  out  1  memory read request, held until mem_readAck
- mem_readReq_addr  out  ADDR_WIDTH  registered read address
- mem_readAck  in  1  memory read done pulse
- mem_readReq_data  in  DATA_WIDTH  read data, valid with mem_readAck

## Operation
- States: IDLE, ISSUE, RESP.
- IDLE: eligible client = any request (write or read) asserted and not masked. None -> stay. One -> grant it. Both -> grant priority pointer. Latch op, address, data, grant index; go ISSUE.
- Same client asserting write and read together: write served first; read stays pending.
- ISSUE: mem_writeReq or mem_readReq high (matching latched op), address/data stable. On the matching mem ack: capture read data if read, go RESP. Non-matching ack ignored.
- RESP: pulse writeAck_k or readAck_k for granted k; update readReq_data_k on reads; priority pointer := 1-k; lockout mask := k for next cycle; go IDLE.
- Lockout: granted client ineligible for exactly the first IDLE cycle after RESP, so a request still high one cycle after ack is not re-granted. Client contract: drop or replace request by the cycle after ack.
- Pointer reset value: client 0.
- Only one memory transaction outstanding; mem_writeReq and mem_readReq never both high.

## Timing
- Reset (async assert): state IDLE, all req/ack outputs 0, mem address/data 0, readReq_data_0/_1 0, pointer 0, mask none. An in-flight memory transaction is abandoned; mem acks arriving in IDLE are ignored.
- Request sampled high in IDLE at edge N -> mem request high from N+1.
- mem ack sampled at edge M -> mem request low and client ack high from M+1 for one cycle; readReq_data_k updated at M+1.
- Earliest next grant evaluated at edge M+2 (masked client excluded); next mem request at M+3.
- Minimum per-transaction occupancy: 4 cycles with zero-wait memory (ack in first ISSUE cycle).
- Mem ack in same cycle ISSUE entered is accepted.

## Structure
- Package mem_arb_pkg: state encoding (IDLE, ISSUE, RESP), client index constants, op encoding (OP_WRITE, OP_READ).
- Sub-module rr_arbiter2: combinational 2-way grant from request vector, mask and priority pointer; outputs grant valid and index. FSM, latches and response routing in mem_req_arbiter.

## Test plan
- Single write from client 0, addr 0x10 data 0xDEADBEEF, mem ack after 3 cycles -> mem_writeReq with those values from N+1, writeAck_0 pulse exactly one cycle, writeAck_1 never.
- Both clients read simultaneously from reset (addr 0x20 / 0x24, memory returns 0x11 / 0x22) -> client 0 served first, then client 1; readReq_data_0=0x11, readReq_data_1=0x22.
- Client 1 holds request one cycle past ack, client 0 idle -> no duplicate grant in lockout cycle; second grant only if still requested in the following cycle.
- Client 0 asserts write and read together -> write issued first, read issued only after writeAck_0.
- Continuous requests from both clients for 8 transactions -> strict alternation 0,1,0,1…, never two memory requests concurrently.
- Assert rst_n low during ISSUE, then release and send a stray mem_readAck -> all outputs 0, no client ack generated, next request handled normally.

Source files
------------

// File: rtl/mem_req_arbiter_pkg.sv
// Shared types for the two-client memory request arbiter: FSM states,
// client indices and the latched operation kind.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  typedef enum logic {
    OP_WRITE = 1'b0,
    OP_READ  = 1'b1
  } op_e;

  localparam logic CLIENT_0 = 1'b0;
  localparam logic CLIENT_1 = 1'b1;

endpackage

// File: rtl/mem_req_arbiter_if.sv
// Bundle of the two client bridge ports and the single scratchpad port.
// The arbiter sits on the slave modport; the environment drives the master.
interface mem_req_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  writeReq_0, writeReq_1;
  logic [DATA_WIDTH-1:0] writeReq_data_0, writeReq_data_1;
  logic [ADDR_WIDTH-1:0] writeReq_addr_0, writeReq_addr_1;
  logic                  writeAck_0, writeAck_1;
  logic                  readReq_0, readReq_1;
  logic [ADDR_WIDTH-1:0] readReq_addr_0, readReq_addr_1;
  logic                  readAck_0, readAck_1;
  logic [DATA_WIDTH-1:0] readReq_data_0, readReq_data_1;

  logic                  mem_writeReq;
  logic [DATA_WIDTH-1:0] mem_writeReq_data;
  logic [ADDR_WIDTH-1:0] mem_writeReq_addr;
  logic                  mem_writeAck;
  logic                  mem_readReq;
  logic [ADDR_WIDTH-1:0] mem_readReq_addr;
  logic                  mem_readAck;
  logic [DATA_WIDTH-1:0] mem_readReq_data;

  modport slave (
    input  writeReq_0, writeReq_1, writeReq_data_0, writeReq_data_1,
           writeReq_addr_0, writeReq_addr_1,
           readReq_0, readReq_1, readReq_addr_0, readReq_addr_1,
           mem_writeAck, mem_readAck, mem_readReq_data,
    output writeAck_0, writeAck_1, readAck_0, readAck_1,
           readReq_data_0, readReq_data_1,
           mem_writeReq, mem_writeReq_data, mem_writeReq_addr,
           mem_readReq, mem_readReq_addr
  );

  modport master (
    output writeReq_0, writeReq_1, writeReq_data_0, writeReq_data_1,
           writeReq_addr_0, writeReq_addr_1,
           readReq_0, readReq_1, readReq_addr_0, readReq_addr_1,
           mem_writeAck, mem_readAck, mem_readReq_data,
    input  writeAck_0, writeAck_1, readAck_0, readAck_1,
           readReq_data_0, readReq_data_1,
           mem_writeReq, mem_writeReq_data, mem_writeReq_addr,
           mem_readReq, mem_readReq_addr
  );
endinterface

// File: rtl/mem_req_arbiter_rr_arbiter2.sv
// Combinational two-way round-robin pick: drops the locked-out client,
// then breaks a tie with the priority pointer.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       mask_valid,
  input  logic       mask_idx,
  input  logic       ptr,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  logic [1:0] elig;

  always_comb begin
    // NOTE: every output is assigned before any branch so no latch is inferred.
    elig = req;
    if (mask_valid) elig[mask_idx] = 1'b0;
    gnt_valid = |elig;
    case (elig)
      2'b01:   gnt_idx = CLIENT_0;
      2'b10:   gnt_idx = CLIENT_1;
      default: gnt_idx = ptr;
    endcase
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Shares one scratchpad port between two bus bridges: round-robin grant,
// one outstanding transaction, acks and read data routed back to the owner.
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_req_arbiter_if.slave bus
);

  state_e                      state_q, state_d;
  op_e                         op_q, op_d;
  logic                        gnt_q, gnt_d;
  logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
  logic [DATA_WIDTH-1:0]       wdata_q, wdata_d;
  logic                        mem_wreq_q, mem_wreq_d;
  logic                        mem_rreq_q, mem_rreq_d;
  logic [1:0]                  wack_q, wack_d;
  logic [1:0]                  rack_q, rack_d;
  logic [1:0][DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic                        ptr_q, ptr_d;
  logic                        mask_valid_q, mask_valid_d;
  logic                        mask_idx_q, mask_idx_d;

  logic [1:0]                  wr_req, rd_req;
  logic [1:0][ADDR_WIDTH-1:0]  wr_addr, rd_addr;
  logic [1:0][DATA_WIDTH-1:0]  wr_data;
  logic                        gnt_valid, gnt_idx, ack_match;

  assign wr_req  = {bus.writeReq_1, bus.writeReq_0};
  assign rd_req  = {bus.readReq_1, bus.readReq_0};
  assign wr_addr = {bus.writeReq_addr_1, bus.writeReq_addr_0};
  assign rd_addr = {bus.readReq_addr_1, bus.readReq_addr_0};
  assign wr_data = {bus.writeReq_data_1, bus.writeReq_data_0};

  rr_arbiter2 u_rr (
    .req        (wr_req | rd_req),
    .mask_valid (mask_valid_q),
    .mask_idx   (mask_idx_q),
    .ptr        (ptr_q),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx)
  );

  // An ack for the other operation kind is not ours and is ignored.
  assign ack_match = (op_q == OP_WRITE) ? bus.mem_writeAck : bus.mem_readAck;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    gnt_d        = gnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    mem_wreq_d   = mem_wreq_q;
    mem_rreq_d   = mem_rreq_q;
    wack_d       = '0;
    rack_d       = '0;
    rdata_d      = rdata_q;
    ptr_d        = ptr_q;
    mask_valid_d = 1'b0;
    mask_idx_d   = mask_idx_q;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          gnt_d   = gnt_idx;
          state_d = ISSUE;
          // A client asking for both gets its write first; the read waits.
          if (wr_req[gnt_idx]) begin
            op_d       = OP_WRITE;
            addr_d     = wr_addr[gnt_idx];
            wdata_d    = wr_data[gnt_idx];
            mem_wreq_d = 1'b1;
          end else begin
            op_d       = OP_READ;
            addr_d     = rd_addr[gnt_idx];
            mem_rreq_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (ack_match) begin
          mem_wreq_d = 1'b0;
          mem_rreq_d = 1'b0;
          state_d    = RESP;
          if (op_q == OP_WRITE) begin
            wack_d[gnt_q] = 1'b1;
          end else begin
            rack_d[gnt_q]  = 1'b1;
            rdata_d[gnt_q] = bus.mem_readReq_data;
          end
        end
      end
      RESP: begin
        ptr_d        = ~gnt_q;
        mask_valid_d = 1'b1;
        mask_idx_d   = gnt_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: datapath registers are reset as well, so the bus reads zero out of reset.
      state_q      <= IDLE;
      op_q         <= OP_WRITE;
      gnt_q        <= CLIENT_0;
      addr_q       <= '0;
      wdata_q      <= '0;
      mem_wreq_q   <= 1'b0;
      mem_rreq_q   <= 1'b0;
      wack_q       <= '0;
      rack_q       <= '0;
      rdata_q      <= '0;
      ptr_q        <= CLIENT_0;
      mask_valid_q <= 1'b0;
      mask_idx_q   <= CLIENT_0;
    end else begin
      // NOTE: non-blocking so every flop updates from the pre-edge values.
      state_q      <= state_d;
      op_q         <= op_d;
      gnt_q        <= gnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      mem_wreq_q   <= mem_wreq_d;
      mem_rreq_q   <= mem_rreq_d;
      wack_q       <= wack_d;
      rack_q       <= rack_d;
      rdata_q      <= rdata_d;
      ptr_q        <= ptr_d;
      mask_valid_q <= mask_valid_d;
      mask_idx_q   <= mask_idx_d;
    end
  end

  assign bus.writeAck_0        = wack_q[0];
  assign bus.writeAck_1        = wack_q[1];
  assign bus.readAck_0         = rack_q[0];
  assign bus.readAck_1         = rack_q[1];
  assign bus.readReq_data_0    = rdata_q[0];
  assign bus.readReq_data_1    = rdata_q[1];
  assign bus.mem_writeReq      = mem_wreq_q;
  assign bus.mem_readReq       = mem_rreq_q;
  assign bus.mem_writeReq_addr = addr_q;
  assign bus.mem_readReq_addr  = addr_q;
  assign bus.mem_writeReq_data = wdata_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Randomized scenario bench for mem_req_arbiter with a behavioural memory
// responder and per-client expected-data shadows.
module tb_mem_req_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_req_arbiter_if bus ();
  mem_req_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          is_read;
    logic [31:0] addr;
    logic [31:0] data;
  } mem_txn_t;

  mem_txn_t    log_q[$];
  logic [31:0] mem_model [logic [31:0]];
  bit          resp_en = 1'b1;
  bit          stray_pending = 1'b0;
  int          lat_min = 0, lat_max = 0, cur_lat = 0, wait_cnt = 0;

  function automatic logic [31:0] default_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return default_word(a);
  endfunction

  // Memory side: acks after cur_lat wait cycles, logs each transaction and
  // checks that the two memory requests are never high together.
  always @(negedge clk) begin
    total++;
    if (bus.mem_writeReq && bus.mem_readReq) begin
      bad++;
      $display("FAIL mem_excl: wr=%0b rd=%0b, want not both", bus.mem_writeReq, bus.mem_readReq);
    end
    if (!rst_n) begin
      wait_cnt = 0;
      bus.mem_writeAck = 1'b0;
      bus.mem_readAck  = 1'b0;
    end else if (bus.mem_writeAck || bus.mem_readAck) begin
      bus.mem_writeAck = 1'b0;
      bus.mem_readAck  = 1'b0;
    end else if (stray_pending) begin
      bus.mem_readReq_data = 32'hBAD0_BAD0;
      bus.mem_readAck      = 1'b1;
      stray_pending        = 1'b0;
    end else if (resp_en && (bus.mem_writeReq || bus.mem_readReq)) begin
      if (wait_cnt >= cur_lat) begin
        if (bus.mem_writeReq) begin
          mem_model[bus.mem_writeReq_addr] = bus.mem_writeReq_data;
          log_q.push_back('{1'b0, bus.mem_writeReq_addr, bus.mem_writeReq_data});
          bus.mem_writeAck = 1'b1;
        end else begin
          bus.mem_readReq_data = mem_read(bus.mem_readReq_addr);
          log_q.push_back('{1'b1, bus.mem_readReq_addr, bus.mem_readReq_data});
          bus.mem_readAck = 1'b1;
        end
        wait_cnt = 0;
        cur_lat  = $urandom_range(lat_max, lat_min);
      end else begin
        wait_cnt++;
      end
    end
  end

  task automatic drive_write(input bit k, input bit en, input logic [31:0] a, input logic [31:0] d);
    if (k) begin
      bus.writeReq_1 = en; bus.writeReq_addr_1 = a; bus.writeReq_data_1 = d;
    end else begin
      bus.writeReq_0 = en; bus.writeReq_addr_0 = a; bus.writeReq_data_0 = d;
    end
  endtask

  task automatic drive_read(input bit k, input bit en, input logic [31:0] a);
    if (k) begin
      bus.readReq_1 = en; bus.readReq_addr_1 = a;
    end else begin
      bus.readReq_0 = en; bus.readReq_addr_0 = a;
    end
  endtask

  function automatic bit wack(input bit k);
    return k ? bus.writeAck_1 : bus.writeAck_0;
  endfunction

  function automatic bit rack(input bit k);
    return k ? bus.readAck_1 : bus.readAck_0;
  endfunction

  function automatic logic [31:0] rdata(input bit k);
    return k ? bus.readReq_data_1 : bus.readReq_data_0;
  endfunction

  task automatic set_lat(input int lo, input int hi);
    lat_min = lo; lat_max = hi; cur_lat = $urandom_range(hi, lo);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive_write(0, 0, '0, '0); drive_write(1, 0, '0, '0);
    drive_read(0, 0, '0);      drive_read(1, 0, '0);
    stray_pending = 1'b0;
    resp_en = 1'b1;
    bus.mem_readReq_data = '0;
    set_lat(0, 0);
    repeat (2) @(negedge clk);
    log_q.delete();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({bus.writeAck_0, bus.writeAck_1, bus.readAck_0, bus.readAck_1} !== 4'b0) begin
      bad++; $display("FAIL reset_acks: got %b want 0000",
                      {bus.writeAck_0, bus.writeAck_1, bus.readAck_0, bus.readAck_1});
    end
    total++;
    if ({bus.mem_writeReq, bus.mem_readReq} !== 2'b00) begin
      bad++; $display("FAIL reset_memreq: got %b want 00", {bus.mem_writeReq, bus.mem_readReq});
    end
    total++;
    if ({bus.mem_writeReq_addr, bus.mem_readReq_addr, bus.mem_writeReq_data} !== 96'h0) begin
      bad++; $display("FAIL reset_memaddr: got %h %h %h want 0", bus.mem_writeReq_addr,
                      bus.mem_readReq_addr, bus.mem_writeReq_data);
    end
    total++;
    if ({bus.readReq_data_0, bus.readReq_data_1} !== 64'h0) begin
      bad++; $display("FAIL reset_rdata: got %h %h want 0", bus.readReq_data_0, bus.readReq_data_1);
    end
  endtask

  task automatic test_single_write();
    int n_ack0 = 0, n_ack1 = 0, first_ack = -1, unstable = 0;
    do_reset();
    set_lat(3, 3);
    drive_write(0, 1, 32'h10, 32'hDEAD_BEEF);
    @(negedge clk);
    total++;
    if (bus.mem_writeReq !== 1'b1 || bus.mem_readReq !== 1'b0) begin
      bad++; $display("FAIL sw_issue: wr=%b rd=%b want 1 0", bus.mem_writeReq, bus.mem_readReq);
    end
    total++;
    if (bus.mem_writeReq_addr !== 32'h10 || bus.mem_writeReq_data !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL sw_payload: got %h/%h want 10/deadbeef",
                      bus.mem_writeReq_addr, bus.mem_writeReq_data);
    end
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.mem_writeReq && (bus.mem_writeReq_addr !== 32'h10 ||
                               bus.mem_writeReq_data !== 32'hDEAD_BEEF)) unstable++;
      if (bus.writeAck_1) n_ack1++;
      if (bus.writeAck_0) begin
        n_ack0++;
        if (first_ack < 0) first_ack = i;
        drive_write(0, 0, '0, '0);
      end
    end
    total++;
    if (first_ack != 4) begin
      bad++; $display("FAIL sw_latency: ack at cycle %0d want 4", first_ack);
    end
    total++;
    if (n_ack0 != 1 || n_ack1 != 0) begin
      bad++; $display("FAIL sw_ackpulse: ack0 cycles=%0d ack1 cycles=%0d want 1 0", n_ack0, n_ack1);
    end
    total++;
    if (unstable != 0) begin
      bad++; $display("FAIL sw_stable: %0d unstable cycles want 0", unstable);
    end
    total++;
    if (log_q.size() != 1) begin
      bad++; $display("FAIL sw_count: %0d mem txns want 1", log_q.size());
    end
  endtask

  task automatic test_dual_read();
    bit order[$];
    do_reset();
    set_lat(0, 2);
    mem_model[32'h20] = 32'h11;
    mem_model[32'h24] = 32'h22;
    drive_read(0, 1, 32'h20);
    drive_read(1, 1, 32'h24);
    for (int i = 0; i < 40 && order.size() < 2; i++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (rack(k[0])) begin
          order.push_back(k[0]);
          total++;
          if (rdata(k[0]) !== (k == 0 ? 32'h11 : 32'h22)) begin
            bad++; $display("FAIL dr_data%0d: got %h want %h", k, rdata(k[0]), k == 0 ? 32'h11 : 32'h22);
          end
          drive_read(k[0], 0, '0);
        end
      end
    end
    total++;
    if (order.size() != 2) begin
      bad++; $display("FAIL dr_count: %0d read acks want 2", order.size());
    end else if (order[0] !== 1'b0 || order[1] !== 1'b1) begin
      bad++; $display("FAIL dr_order: got %0d,%0d want 0,1", order[0], order[1]);
    end
    repeat (3) @(negedge clk);
    total++;
    if (bus.readReq_data_0 !== 32'h11 || bus.readReq_data_1 !== 32'h22) begin
      bad++; $display("FAIL dr_hold: got %h %h want 11 22", bus.readReq_data_0, bus.readReq_data_1);
    end
  endtask

  // Client 1 keeps its write high after the ack; extra=0 holds it only
  // through the lockout cycle, extra=1 holds it one cycle longer.
  task automatic lockout_case(input bit extra);
    bit found = 1'b0;
    int stray = 0;
    do_reset();
    set_lat(0, 0);
    drive_write(1, 1, 32'h100, 32'hCAFE_0001);
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (bus.writeAck_1) found = 1'b1;
    end
    total++;
    if (!found) begin
      bad++; $display("FAIL lo_ack%0d: no writeAck_1 within 20 cycles", extra);
    end
    repeat (2) @(negedge clk);
    total++;
    if (bus.mem_writeReq !== 1'b0) begin
      bad++; $display("FAIL lo_masked%0d: mem_writeReq=%b in lockout want 0", extra, bus.mem_writeReq);
    end
    if (!extra) begin
      drive_write(1, 0, '0, '0);
      repeat (8) begin
        @(negedge clk);
        if (bus.mem_writeReq || bus.mem_readReq || bus.writeAck_1) stray++;
      end
      total++;
      if (stray != 0 || log_q.size() != 1) begin
        bad++; $display("FAIL lo_nodup: %0d busy cycles, %0d txns want 0, 1", stray, log_q.size());
      end
    end else begin
      @(negedge clk);
      total++;
      if (bus.mem_writeReq !== 1'b1) begin
        bad++; $display("FAIL lo_regrant: mem_writeReq=%b want 1", bus.mem_writeReq);
      end
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
        if (bus.writeAck_1) found = 1'b1;
        else @(negedge clk);
      end
      drive_write(1, 0, '0, '0);
      repeat (3) @(negedge clk);
      total++;
      if (!found || log_q.size() != 2) begin
        bad++; $display("FAIL lo_second: ack=%0b txns=%0d want 1, 2", found, log_q.size());
      end
    end
  endtask

  task automatic test_lockout();
    lockout_case(1'b0);
    lockout_case(1'b1);
  endtask

  task automatic test_write_then_read();
    logic [31:0] d = $urandom;
    int w_at = -1, r_at = -1, early = 0;
    do_reset();
    set_lat(0, 3);
    drive_write(0, 1, 32'h40, d);
    drive_read(0, 1, 32'h40);
    for (int i = 0; i < 60 && r_at < 0; i++) begin
      @(negedge clk);
      if (w_at < 0 && bus.mem_readReq) early++;
      if (bus.writeAck_0) begin w_at = i; drive_write(0, 0, '0, '0); end
      if (bus.readAck_0) begin
        r_at = i;
        total++;
        if (bus.readReq_data_0 !== d) begin
          bad++; $display("FAIL wr_rdata: got %h want %h", bus.readReq_data_0, d);
        end
        drive_read(0, 0, '0);
      end
    end
    total++;
    if (w_at < 0 || r_at < 0 || w_at >= r_at || early != 0) begin
      bad++; $display("FAIL wr_order: write ack %0d read ack %0d early reads %0d want write first",
                      w_at, r_at, early);
    end
    total++;
    if (log_q.size() != 2) begin
      bad++; $display("FAIL wr_count: %0d txns want 2", log_q.size());
    end else if (log_q[0].is_read || !log_q[1].is_read || log_q[1].addr !== 32'h40) begin
      bad++; $display("FAIL wr_memseq: got read flags %0b,%0b addr %h want 0,1 at 40",
                      log_q[0].is_read, log_q[1].is_read, log_q[1].addr);
    end
  endtask

  task automatic client_proc(input bit k, input int n_txn);
    logic [31:0] shadow [logic [31:0]];
    for (int n = 0; n < n_txn; n++) begin
      bit          is_read = $urandom_range(1, 0) == 1;
      logic [31:0] a = 32'h1000 | (32'(k) << 8) | (32'($urandom_range(7, 0)) << 2);
      logic [31:0] d = $urandom;
      logic [31:0] exp;
      bit          found = 1'b0;
      if (is_read) begin
        exp = shadow.exists(a) ? shadow[a] : default_word(a);
        drive_read(k, 1, a);
      end else begin
        shadow[a] = d;
        drive_write(k, 1, a, d);
      end
      for (int c = 0; c < 60 && !found; c++) begin
        @(negedge clk);
        if (is_read ? rack(k) : wack(k)) found = 1'b1;
      end
      total++;
      if (!found) begin
        bad++; $display("FAIL b2b_timeout: client %0d txn %0d no ack in 60 cycles", k, n);
      end else if (is_read && rdata(k) !== exp) begin
        bad++; $display("FAIL b2b_rdata: client %0d got %h want %h", k, rdata(k), exp);
      end
      drive_write(k, 0, '0, '0);
      drive_read(k, 0, '0);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_lat(0, 2);
    fork
      client_proc(1'b0, 4);
      client_proc(1'b1, 4);
    join
    repeat (2) @(negedge clk);
    total++;
    if (log_q.size() != 8) begin
      bad++; $display("FAIL b2b_count: %0d txns want 8", log_q.size());
    end
    for (int i = 0; i < log_q.size(); i++) begin
      total++;
      if (log_q[i].addr[8] !== 1'(i % 2)) begin
        bad++; $display("FAIL b2b_alt: txn %0d from client %0d want %0d", i, log_q[i].addr[8], i % 2);
      end
    end
  endtask

  task automatic test_reset_midflight();
    bit found = 1'b0;
    int busy = 0;
    logic [31:0] d = $urandom;
    do_reset();
    resp_en = 1'b0;
    drive_read(1, 1, 32'h80);
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (bus.mem_readReq) found = 1'b1;
    end
    total++;
    if (!found) begin
      bad++; $display("FAIL rm_issue: mem_readReq never rose, want 1");
    end
    #2 rst_n = 1'b0;
    drive_read(1, 0, '0);
    #1;
    total++;
    if ({bus.mem_readReq, bus.mem_writeReq, bus.readAck_1, bus.mem_readReq_addr} !== 35'h0) begin
      bad++; $display("FAIL rm_async: got req=%b ack=%b addr=%h want all 0",
                      bus.mem_readReq, bus.readAck_1, bus.mem_readReq_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    stray_pending = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (bus.writeAck_0 || bus.writeAck_1 || bus.readAck_0 || bus.readAck_1 ||
          bus.mem_readReq || bus.mem_writeReq) busy++;
    end
    total++;
    if (busy != 0 || bus.readReq_data_1 !== 32'h0) begin
      bad++; $display("FAIL rm_stray: %0d active cycles rdata1=%h want 0 0", busy, bus.readReq_data_1);
    end
    resp_en = 1'b1;
    drive_write(0, 1, 32'h90, d);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (bus.writeAck_0) found = 1'b1;
    end
    drive_write(0, 0, '0, '0);
    total++;
    if (!found || log_q.size() != 1) begin
      bad++; $display("FAIL rm_recover: ack=%0b txns=%0d want 1 1", found, log_q.size());
    end else if (log_q[0].addr !== 32'h90 || log_q[0].data !== d) begin
      bad++; $display("FAIL rm_payload: got %h/%h want 90/%h", log_q[0].addr, log_q[0].data, d);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_dual_read();
    test_lockout();
    test_write_then_read();
    test_back_to_back();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
